// File: rtl/onewire_slave_phy.sv
// 1-wire slave physical layer: reset/presence handling, slot sampling
// and open-drain answer of read slots from an armed transmit byte.
`timescale 1ns/1ps
module onewire_slave_phy #(
  parameter int CLK_US = 4,
  parameter int RST_US = 480,
  parameter int PDH_US = 30,
  parameter int PDL_US = 120,
  parameter int SMP_US = 30,
  parameter int RDL_US = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       owr_i,
  output logic       owr_oe,
  output logic       rst_det,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  input  logic [7:0] tx_data,
  input  logic       tx_vld,
  output logic       tx_rdy,
  output logic       tx_done
);

  localparam int RST_C = CLK_US * RST_US;
  localparam int CW    = $clog2(RST_C + 1);

  localparam logic [CW-1:0] RST_M1 = CW'(RST_C - 1);
  localparam logic [CW-1:0] SMP_M1 = CW'(CLK_US * SMP_US - 1);
  localparam logic [CW-1:0] RDL_M1 = CW'(CLK_US * RDL_US - 1);
  localparam logic [CW-1:0] PDH_M1 = CW'(CLK_US * PDH_US - 1);
  localparam logic [CW-1:0] PDL_M1 = CW'(CLK_US * PDL_US - 1);
  localparam logic [CW-1:0] CNT_MX = '1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SLOT     = 3'd1;
  localparam logic [2:0] S_RST_LOW  = 3'd2;
  localparam logic [2:0] S_PRS_WAIT = 3'd3;
  localparam logic [2:0] S_PRS_LOW  = 3'd4;
  localparam logic [2:0] S_PRS_REL  = 3'd5;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] low_cnt_q, low_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_vld_q, rx_vld_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          armed_q, armed_d;
  logic          tx_done_q, tx_done_d;
  logic          rst_det_q, rst_det_d;

  logic          bus;
  logic          fall;
  logic          low_hit;
  logic          accept;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] low_inc;

  assign bus     = sync2_q;
  assign fall    = ~bus & prev_q;
  assign cnt_inc = (cnt_q == CNT_MX) ? cnt_q : cnt_q + 1'b1;
  assign low_inc = (low_cnt_q == CNT_MX) ? low_cnt_q : low_cnt_q + 1'b1;

  // A 0 bit is held from the slot's first counted cycle to the read window end
  assign owr_oe = (state_q == S_PRS_LOW) |
                  ((state_q == S_SLOT) & armed_q & ~tx_sh_q[0] &
                   (cnt_q <= RDL_M1));

  assign tx_rdy = ~armed_q & (bit_cnt_q == 3'd0) &
                  (state_q != S_SLOT) & (state_q != S_RST_LOW);
  assign accept = tx_vld & tx_rdy;

  assign low_hit = ~bus & ~owr_oe & (low_cnt_q >= RST_M1);

  assign rst_det = rst_det_q;
  assign rx_data = rx_data_q;
  assign rx_vld  = rx_vld_q;
  assign tx_done = tx_done_q;

  always_comb begin
    sync1_d   = owr_i;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    low_cnt_d = (~bus & ~owr_oe) ? low_inc : '0;
    bit_cnt_d = bit_cnt_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    rx_vld_d  = 1'b0;
    tx_sh_d   = tx_sh_q;
    armed_d   = armed_q;
    tx_done_d = 1'b0;
    rst_det_d = 1'b0;

    if (accept) begin
      armed_d = 1'b1;
      tx_sh_d = tx_data;
    end

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = S_SLOT;
        end
      end
      S_SLOT: begin
        cnt_d = cnt_inc;
        // The slot always runs to its sample point; a 1 bit is a released bus
        if (cnt_q == SMP_M1) begin
          rx_sh_d   = {bus, rx_sh_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (armed_q) tx_sh_d = {1'b0, tx_sh_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            rx_data_d = {bus, rx_sh_q[7:1]};
            rx_vld_d  = 1'b1;
            if (armed_q) begin
              tx_done_d = 1'b1;
              armed_d   = 1'b0;
            end
          end
        end
        if ((cnt_q >= SMP_M1) & bus) begin
          state_d = S_IDLE;
        end else if (~bus & (cnt_q >= RST_M1)) begin
          state_d = S_RST_LOW;
        end
      end
      S_RST_LOW: begin
        if (bus) begin
          rst_det_d = 1'b1;
          bit_cnt_d = 3'd0;
          rx_sh_d   = 8'h00;
          armed_d   = 1'b0;
          cnt_d     = '0;
          state_d   = S_PRS_WAIT;
        end
      end
      S_PRS_WAIT: begin
        cnt_d = cnt_inc;
        if (cnt_q == PDH_M1) begin
          cnt_d   = '0;
          state_d = S_PRS_LOW;
        end
      end
      S_PRS_LOW: begin
        cnt_d = cnt_inc;
        if (cnt_q == PDL_M1) begin
          cnt_d   = '0;
          state_d = S_PRS_REL;
        end
      end
      S_PRS_REL: begin
        if (bus) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Long low outside a slot is a master reset, even mid-handshake
    if (low_hit & ((state_q == S_IDLE) | (state_q == S_PRS_WAIT) |
                   (state_q == S_PRS_REL))) begin
      state_d = S_RST_LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      low_cnt_q <= '0;
      bit_cnt_q <= 3'd0;
      rx_sh_q   <= 8'h00;
      rx_data_q <= 8'h00;
      rx_vld_q  <= 1'b0;
      tx_sh_q   <= 8'h00;
      armed_q   <= 1'b0;
      tx_done_q <= 1'b0;
      rst_det_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      low_cnt_q <= low_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_vld_q  <= rx_vld_d;
      tx_sh_q   <= tx_sh_d;
      armed_q   <= armed_d;
      tx_done_q <= tx_done_d;
      rst_det_q <= rst_det_d;
    end
  end

endmodule

// File: tb/tb_onewire_slave_phy.sv
// Directed bench for onewire_slave_phy: a 1-wire master model on a
// wired-AND bus, byte vectors in a table plus reset corner sequences.
`timescale 1ns/1ps
module tb_onewire_slave_phy;

  typedef struct {
    logic       arm;
    logic [7:0] tx;
    logic [7:0] m;
    int         lo1;
    logic [7:0] exp_rx;
    logic [7:0] exp_drv;
    logic       exp_done;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_low;
  wire        owr_i;
  logic       owr_oe;
  logic       rst_det;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic       tx_rdy;
  logic       tx_done;

  int n_run  = 0;
  int n_fail = 0;
  int n_rxv  = 0;
  int n_done = 0;
  int n_both = 0;
  int n_det  = 0;

  assign owr_i = ~(m_low | owr_oe);

  always #5 clk = ~clk;

  onewire_slave_phy dut (
    .clk     (clk),
    .rst     (rst),
    .owr_i   (owr_i),
    .owr_oe  (owr_oe),
    .rst_det (rst_det),
    .rx_data (rx_data),
    .rx_vld  (rx_vld),
    .tx_data (tx_data),
    .tx_vld  (tx_vld),
    .tx_rdy  (tx_rdy),
    .tx_done (tx_done)
  );

  always @(negedge clk) begin
    if (rx_vld) n_rxv++;
    if (tx_done) n_done++;
    if (rx_vld & tx_done) n_both++;
    if (rst_det) n_det++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic slot(input int lo_us, output int oe_n);
    oe_n = 0;
    for (int c = 0; c < 280; c++) begin
      m_low = (c < lo_us * 4);
      @(negedge clk);
      if (owr_oe) oe_n++;
    end
    m_low = 1'b0;
  endtask

  task automatic arm_tx(input logic [7:0] d, input string nm);
    chk({nm, " rdy_pre"}, int'(tx_rdy), 1);
    tx_data = d;
    tx_vld  = 1'b1;
    @(negedge clk);
    tx_vld  = 1'b0;
    chk({nm, " rdy_armed"}, int'(tx_rdy), 0);
  endtask

  task automatic bus_reset(input int us, input string nm);
    int d0, t_det, t_on, t_off;
    d0 = n_det; t_det = -1; t_on = -1; t_off = -1;
    m_low = 1'b1;
    idle(us * 4);
    m_low = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (rst_det && t_det < 0) t_det = c;
      if (owr_oe && t_on < 0) t_on = c;
      if (!owr_oe && t_on >= 0 && t_off < 0) t_off = c;
    end
    chk({nm, " det_cnt"}, n_det - d0, 1);
    chk({nm, " det_lat"}, t_det, 2);
    chk({nm, " prs_dly"}, t_on - t_det, 120);
    chk({nm, " prs_len"}, t_off - t_on, 480);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int r0, d0, b0, n;
    if (v.arm) arm_tx(v.tx, nm);
    r0 = n_rxv; d0 = n_done; b0 = n_both;
    for (int b = 0; b < 8; b++) begin
      slot(v.m[b] ? v.lo1 : 60, n);
      chk($sformatf("%s drv%0d", nm, b), n, v.exp_drv[b] ? 120 : 0);
    end
    idle(20);
    chk({nm, " rx_vld"}, n_rxv - r0, 1);
    chk({nm, " rx_data"}, int'(rx_data), int'(v.exp_rx));
    chk({nm, " tx_done"}, n_done - d0, int'(v.exp_done));
    chk({nm, " coincide"}, n_both - b0, int'(v.exp_done));
    chk({nm, " rdy_post"}, int'(tx_rdy), 1);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t v;
    int   r0, d0, n;

    vecs[0] = '{arm:1'b0, tx:8'h00, m:8'h55, lo1:6,
                exp_rx:8'h55, exp_drv:8'h00, exp_done:1'b0};
    vecs[1] = '{arm:1'b1, tx:8'hA3, m:8'hFF, lo1:1,
                exp_rx:8'hA3, exp_drv:8'h5C, exp_done:1'b1};
    vecs[2] = '{arm:1'b0, tx:8'h00, m:8'h3C, lo1:6,
                exp_rx:8'h3C, exp_drv:8'h00, exp_done:1'b0};
    vecs[3] = '{arm:1'b1, tx:8'h00, m:8'hFF, lo1:1,
                exp_rx:8'h00, exp_drv:8'hFF, exp_done:1'b1};
    vecs[4] = '{arm:1'b1, tx:8'h81, m:8'hF0, lo1:1,
                exp_rx:8'h80, exp_drv:8'h7E, exp_done:1'b1};

    rst = 1'b1; m_low = 1'b0; tx_vld = 1'b0; tx_data = 8'h00;
    idle(3);
    chk("rst owr_oe", int'(owr_oe), 0);
    chk("rst rst_det", int'(rst_det), 0);
    chk("rst rx_vld", int'(rx_vld), 0);
    chk("rst tx_done", int'(tx_done), 0);
    chk("rst tx_rdy", int'(tx_rdy), 1);
    chk("rst rx_data", int'(rx_data), 0);
    rst = 1'b0;
    idle(10);

    r0 = n_rxv;
    bus_reset(500, "reset1");
    chk("reset1 no_rx", n_rxv - r0, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    r0 = n_rxv;
    for (int b = 0; b < 3; b++) slot(60, n);
    bus_reset(500, "midrst");
    chk("midrst no_rx", n_rxv - r0, 0);
    v = '{arm:1'b0, tx:8'h00, m:8'hF0, lo1:6,
          exp_rx:8'hF0, exp_drv:8'h00, exp_done:1'b0};
    run_vec(v, "midrst_f0");

    arm_tx(8'h00, "drop");
    d0 = n_done;
    bus_reset(500, "drop");
    chk("drop no_done", n_done - d0, 0);
    chk("drop rdy", int'(tx_rdy), 1);
    v = '{arm:1'b0, tx:8'h00, m:8'hFF, lo1:1,
          exp_rx:8'hFF, exp_drv:8'h00, exp_done:1'b0};
    run_vec(v, "drop_rd");

    m_low = 1'b1;
    idle(2000);
    m_low = 1'b0;
    idle(322);
    chk("prsrst pre_oe", int'(owr_oe), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("prsrst owr_oe", int'(owr_oe), 0);
    chk("prsrst tx_rdy", int'(tx_rdy), 1);
    chk("prsrst rx_data", int'(rx_data), 0);
    chk("prsrst rx_vld", int'(rx_vld), 0);
    chk("prsrst tx_done", int'(tx_done), 0);
    chk("prsrst rst_det", int'(rst_det), 0);
    rst = 1'b0;
    idle(10);
    v = '{arm:1'b0, tx:8'h00, m:8'hA5, lo1:6,
          exp_rx:8'hA5, exp_drv:8'h00, exp_done:1'b0};
    run_vec(v, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/onewire_slave_phy.md
Name: onewire_slave_phy

Overview:
- Synthesizable, clocked 1-wire slave (responder) physical layer.
- Detects master reset pulses and answers with a presence pulse.
- Samples each master time slot into received bytes and, when a transmit byte is armed, answers read slots by holding the bus low for 0 bits.
- Sits between the open-drain pad (`owr_i`/`owr_oe`) and a byte-level command/ROM engine; it is the responder to the existing 1-wire master model.

Parameters:
- CLK_US, 4, clock cycles per microsecond; all timing parameters are multiplied by this.
- RST_US, 480, minimum bus-low time (us) recognised as a reset pulse.
- PDH_US, 30, wait (us) from bus release after reset to presence pulse start.
- PDL_US, 120, presence pulse low duration (us).
- SMP_US, 30, sample point (us) after a slot's falling edge.
- RDL_US, 30, hold-low time (us) from the falling edge when transmitting a 0 bit.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- owr_i, input, 1, raw 1-wire bus level (asynchronous).
- owr_oe, output, 1, 1 = pull bus low; open-drain pad enable.
- rst_det, output, 1, one-cycle pulse when a valid reset pulse ends.
- rx_data, output, 8, last received byte, LSB first on the wire.
- rx_vld, output, 1, one-cycle pulse when rx_data is updated.
- tx_data, input, 8, byte to return on the next 8 slots.
- tx_vld, input, 1, tx_data valid.
- tx_rdy, output, 1, ready to accept tx_data.
- tx_done, output, 1, one-cycle pulse when an armed byte has been fully sent.

Behaviour:
- Clocking and reset:
  - One clock `clk`. Reset `rst` is synchronous and active-high.
  - While rst=1: owr_oe=0, rst_det=0, rx_vld=0, tx_done=0, tx_rdy=1, rx_data=8'h00; state IDLE; bit count 0; counter 0.
- Input synchroniser:
  - owr_i passes through a 2-flop synchroniser, giving 2-cycle latency. All decisions use the synchronised level `bus`.
  - A falling edge is `bus`=0 with the previous `bus`=1.
- Counter width: $clog2(CLK_US*RST_US+1) bits, saturating at its maximum.
- States:
  - IDLE: `bus` high. A falling edge sets counter=0 and moves to SLOT.
  - SLOT:
    - The counter increments every cycle.
    - At counter==CLK_US*SMP_US-1, `bus` is sampled and shifted into the rx shift register MSB, shifting right.
    - If a byte is armed and its current bit is 0, owr_oe=1 from the cycle after edge detection until counter==CLK_US*RDL_US-1; otherwise owr_oe=0.
    - After the sample point, `bus` high -> IDLE.
    - `bus` still low when counter reaches CLK_US*RST_US -> RST_LOW.
  - End of byte:
    - On the 8th sample, rx_data <= shifted byte and rx_vld pulses in the next cycle; bit count wraps to 0.
    - If a byte was armed, tx_done pulses in the same cycle as rx_vld, the byte is disarmed and tx_rdy returns to 1.
  - RST_LOW:
    - Wait for `bus` high.
    - On `bus` high: pulse rst_det for one cycle, clear the bit count and rx shift register, discard any armed tx byte (tx_rdy=1, no tx_done), counter=0 -> PRS_WAIT.
  - PRS_WAIT: after CLK_US*PDH_US cycles -> PRS_LOW.
  - PRS_LOW:
    - owr_oe=1 for CLK_US*PDL_US cycles, then owr_oe=0 -> PRS_REL.
    - Falling edges caused by the block's own drive are not slots.
  - PRS_REL: wait for `bus` high, then -> IDLE.
- Reset pulse detection from any state: `bus` low continuously for CLK_US*RST_US cycles while owr_oe=0 -> RST_LOW. This covers reset mid-byte and reset during PRS_WAIT.
- tx handshake:
  - A transfer occurs when tx_vld && tx_rdy, accepted only while bit count==0 and state != SLOT.
  - Acceptance arms the byte; tx_rdy=0 until tx_done or a bus reset.
  - tx_vld while tx_rdy=0 is ignored; the source must hold the byte.
  - A byte accepted in the same cycle as a falling edge applies to that slot.
- Transmitted bits are also sampled into rx, so rx_data echoes the wire, including any 0 bits forced by the master.
- Low pulse shorter than the sample point (`bus` high before sampling): no bit is taken, state -> IDLE, bit count unchanged.

Test Plan:
- CLK_US=4; hold owr_i low 500 us, then release. Required: rst_det pulses once ~2 cycles after release; owr_oe rises 120 cycles later and stays high exactly 480 cycles; no rx_vld.
- After reset, master writes 8'h55 using 6 us low for 1 bits and 60 us low for 0 bits, with 70 us slots. Required: rx_vld once, rx_data=8'h55, owr_oe never asserted.
- Arm tx_data=8'hA3 (tx_rdy falls), master issues 8 read slots with 1 us low. Required: owr_oe held low for 120 cycles on bits 2,3,4,6; rx_data=8'hA3; tx_done and rx_vld coincide; tx_rdy=1 afterwards.
- 3 bits into a write byte, apply a 500 us reset. Required: no rx_vld, rst_det pulse, presence pulse; a following write of 8'hF0 yields rx_data=8'hF0.
- Armed byte 8'h00, bus reset before any slot. Required: tx_rdy returns to 1 with no tx_done; subsequent read slots are not driven.
- Assert rst in the middle of the PRS_LOW presence pulse. Required: owr_oe=0 on the next cycle, state IDLE, and all outputs at their reset values.
